ahb_multi_timer: RTL and testbench
==================================

Name: ahb_multi_timer

Overview:
- Parametrised AHB-Lite slave with NCH independent 32-bit down-counting timers, each with its own prescaler, periodic or one-shot mode, and maskable interrupt.
- Next-generation replacement for the single-channel SoC timer: one instance serves several software timebases.
- Drives per-channel IRQ lines plus a combined TIMER_IRQ to the NVIC.
- Sits on the AHB-Lite decoder/mux alongside the UART, GPIO and 7-segment peripherals.

Parameters:
NCH, 4, number of timer channels (1..16)
CW, 32, counter/LOAD width in bits (8..32)
PW, 8, prescale field width; channel tick divides CLK by (PRESCALE+1)

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
HSEL  input  1  slave select
HADDR  input  32  byte address; bits [7:0] decoded
HTRANS  input  2  transfer type; bit1=1 is NONSEQ/SEQ
HWRITE  input  1  1=write
HSIZE  input  3  ignored; word access assumed
HWDATA  input  32  write data (data phase)
HREADY  input  1  bus ready
HREADYOUT  output  1  constant 1 (zero wait state)
HRDATA  output  32  read data (data phase)
IRQ  output  NCH  per-channel interrupt = PEND[n] & IE[n]
TIMER_IRQ  output  1  OR of IRQ

Behaviour:
- Register map: channel n base = n*0x10; n>=NCH is unmapped.
  - +0x0 LOAD (RW, CW bits).
  - +0x4 VALUE (RO).
  - +0x8 CTRL (RW): bit0 EN; bit1 MODE (0 periodic, 1 one-shot); bit2 IE; bits[4+PW-1:4] PRESCALE.
  - +0xC STATUS: bit0 PEND; write 1 clears, write 0 has no effect.
- Unmapped reads return 0; unmapped writes are ignored. Upper unused bits read 0.
- Address phase:
  - When HSEL & HREADY & HTRANS[1], register addr[7:2] and write flag, and set a valid flag.
  - Otherwise clear the valid flag.
- Data phase:
  - Write commits HWDATA on the following CLK edge.
  - HRDATA is combinational from the registered address and reflects register state before that edge.
  - Back-to-back transfers are supported.
- Reset: all LOAD, VALUE, CTRL, PEND, prescale counters and bus registers go to 0. HRDATA=0, IRQ=0, TIMER_IRQ=0, HREADYOUT=1. Reset mid-count aborts immediately; no IRQ is produced.
- Prescaler (per channel):
  - pcnt counts 0..PRESCALE while EN=1.
  - tick = EN & (pcnt==PRESCALE); pcnt wraps to 0 on tick.
  - pcnt is held at 0 while EN=0.
- Counter, on tick:
  - VALUE!=0: VALUE<=VALUE-1.
  - VALUE==0: PEND<=1, then:
    - periodic: VALUE<=LOAD.
    - one-shot: EN<=0 and VALUE stays 0.
  - Periodic interrupt interval = (LOAD+1)*(PRESCALE+1) CLK cycles.
  - LOAD=0 with PRESCALE=0 periodic sets PEND every cycle.
- LOAD write: loads LOAD and VALUE simultaneously and resets pcnt to 0. A write takes priority over a same-cycle tick decrement or reload.
- CTRL write with EN 0->1: pcnt restarts from 0. VALUE is not reloaded.
- PEND set and STATUS write-1-clear in the same cycle: set wins, PEND stays 1.
- One-shot: a same-cycle CTRL write wins over the auto-clear of EN.
- IRQ is level, registered through PEND, and asserts 1 cycle after the tick that sets PEND. Masking with IE=0 hides IRQ but PEND still latches.
- Channels are fully independent; CW-bit arithmetic wraps modulo 2^CW (only reachable through the reload path).

Test Plan:
- Reset: RESET=1 for 3 cycles mid-count on ch0 -> all reads return 0, TIMER_IRQ=0, HREADYOUT=1 throughout.
- Periodic: ch0 LOAD=4, CTRL=0x5 (EN, IE, PRESCALE=0) -> IRQ[0] rises every 5 cycles after the first; STATUS write 1 drops IRQ[0] the next cycle; it re-asserts 5 cycles later.
- Prescale and one-shot: ch1 LOAD=2, CTRL=0x37 (PRESCALE=3, one-shot, IE, EN) -> PEND after 12 cycles; CTRL reads 0x36 (EN cleared); VALUE holds 0; no further IRQ.
- Collision: STATUS clear issued in the exact cycle ch2 reaches its tick at VALUE==0 -> PEND remains 1, IRQ[2] stays high.
- Multi-channel: ch0 LOAD=3 and ch3 LOAD=7, both periodic with IE -> TIMER_IRQ is the OR of both; masking ch0 (IE=0) leaves only ch3 edges while ch0 STATUS still reads 1.
- Bus: back-to-back write LOAD then read VALUE on ch2 -> read returns the new LOAD value; read at 0x40 with NCH=4 returns 0; HREADYOUT=1 throughout.

Source files
------------

// File: rtl/ahb_multi_timer.sv
// AHB-Lite slave with NCH independent down-counting timers, each with its own
// prescaler, periodic/one-shot mode and maskable level interrupt.
module ahb_multi_timer #(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int PW  = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           HSEL,
  input  logic [31:0]    HADDR,
  input  logic [1:0]     HTRANS,
  input  logic           HWRITE,
  input  logic [2:0]     HSIZE,
  input  logic [31:0]    HWDATA,
  input  logic           HREADY,
  output logic           HREADYOUT,
  output logic [31:0]    HRDATA,
  output logic [NCH-1:0] IRQ,
  output logic           TIMER_IRQ
);

  localparam int MAXCH = 16;

  logic [5:0] addr_reg;
  logic       write_reg;
  logic       valid_reg;
  logic       addr_phase;
  logic       wr_en;
  logic [3:0] sel_ch;
  logic [1:0] sel_off;
  logic       unused_bits;

  logic [MAXCH-1:0][31:0] rd_word;
  logic [MAXCH-1:0]       irq_all;

  assign addr_phase  = HSEL & HREADY & HTRANS[1];
  assign wr_en       = valid_reg & write_reg;
  assign sel_ch      = addr_reg[5:2];
  assign sel_off     = addr_reg[1:0];
  assign unused_bits = ^{HSIZE, HADDR[31:8], HADDR[1:0], HTRANS[0], HWDATA};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_reg  <= '0;
      write_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= addr_phase;
      if (addr_phase) begin
        addr_reg  <= HADDR[7:2];
        write_reg <= HWRITE;
      end
    end
  end

  // Slots beyond NCH read as zero so the read mux can always index all 16.
  genvar gi;
  generate
    for (gi = 0; gi < MAXCH; gi++) begin : g_ch
      if (gi < NCH) begin : g_on
        logic [CW-1:0] load_reg;
        logic [CW-1:0] value_reg;
        logic [PW-1:0] pre_reg;
        logic [PW-1:0] pcnt_reg;
        logic          en_reg;
        logic          mode_reg;
        logic          ie_reg;
        logic          pend_reg;
        logic          hit;
        logic          wr_load;
        logic          wr_ctrl;
        logic          wr_stat;
        logic          tick;
        logic          expire;

        assign hit     = wr_en && (sel_ch == 4'(gi));
        assign wr_load = hit && (sel_off == 2'd0);
        assign wr_ctrl = hit && (sel_off == 2'd2);
        assign wr_stat = hit && (sel_off == 2'd3);
        assign tick    = en_reg && (pcnt_reg == pre_reg);
        assign expire  = tick && (value_reg == '0);

        always_ff @(posedge CLK) begin
          if (RESET) begin
            load_reg  <= '0;
            value_reg <= '0;
            pre_reg   <= '0;
            pcnt_reg  <= '0;
            en_reg    <= 1'b0;
            mode_reg  <= 1'b0;
            ie_reg    <= 1'b0;
            pend_reg  <= 1'b0;
          end else begin
            // A LOAD write beats any same-cycle decrement or reload.
            if (wr_load) begin
              load_reg  <= HWDATA[CW-1:0];
              value_reg <= HWDATA[CW-1:0];
            end else if (tick) begin
              if (value_reg != '0)
                value_reg <= value_reg - CW'(1);
              else if (!mode_reg)
                value_reg <= load_reg;
            end

            if (wr_load || !en_reg || tick)
              pcnt_reg <= '0;
            else
              pcnt_reg <= pcnt_reg + PW'(1);

            if (wr_ctrl) begin
              en_reg   <= HWDATA[0];
              mode_reg <= HWDATA[1];
              ie_reg   <= HWDATA[2];
              pre_reg  <= HWDATA[4 +: PW];
            end else if (expire && mode_reg) begin
              en_reg <= 1'b0;
            end

            // Expiry beats a same-cycle write-1-to-clear.
            if (expire)
              pend_reg <= 1'b1;
            else if (wr_stat && HWDATA[0])
              pend_reg <= 1'b0;
          end
        end

        assign rd_word[gi] = (sel_off == 2'd0) ? 32'(load_reg)  :
                             (sel_off == 2'd1) ? 32'(value_reg) :
                             (sel_off == 2'd2) ? 32'({pre_reg, 1'b0, ie_reg, mode_reg, en_reg}) :
                                                 {31'b0, pend_reg};
        assign irq_all[gi] = pend_reg & ie_reg;
      end else begin : g_off
        assign rd_word[gi] = '0;
        assign irq_all[gi] = 1'b0;
      end
    end
  endgenerate

  assign HREADYOUT = 1'b1;
  assign HRDATA    = (valid_reg && !write_reg) ? rd_word[sel_ch] : 32'h0;
  assign IRQ       = irq_all[NCH-1:0];
  assign TIMER_IRQ = |irq_all;

endmodule

// File: tb/tb_ahb_multi_timer.sv
// Self-checking bench for ahb_multi_timer: register table, then cycle-exact
// sequences for periodic, one-shot, collision, masking and reset behaviour.
module tb_ahb_multi_timer;

  localparam int NCH = 4;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           HSEL;
  logic [31:0]    HADDR;
  logic [1:0]     HTRANS;
  logic           HWRITE;
  logic [2:0]     HSIZE;
  logic [31:0]    HWDATA;
  logic           HREADY;
  logic           HREADYOUT;
  logic [31:0]    HRDATA;
  logic [NCH-1:0] IRQ;
  logic           TIMER_IRQ;

  ahb_multi_timer #(.NCH(NCH), .CW(32), .PW(8)) dut (
    .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .IRQ(IRQ), .TIMER_IRQ(TIMER_IRQ)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic sample_read();
    sb_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: read data with no expected entry");
    end else begin
      e = sb_q.pop_front();
      check(e.name, HRDATA, e.exp);
      $display("rd %s -> 0x%08h", e.name, HRDATA);
    end
    check("hreadyout", {31'b0, HREADYOUT}, 32'd1);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = {24'h0, a};
    step();
    HWDATA = d;
    idle_bus();
    step();
    $display("wr [0x%02h] <= 0x%08h", a, d);
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = {24'h0, a};
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    step();
    idle_bus();
    sample_read();
    step();
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    idle_bus();
    repeat (n) step();
    RESET = 1'b0;
  endtask

  initial begin
    int c0;
    int d;

    RESET  = 1'b1;
    HSEL   = 1'b0;
    HADDR  = '0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
    HWDATA = '0;
    HREADY = 1'b1;

    tbl = '{
      '{1'b1, 8'h00, 32'h1234_5678},
      '{1'b0, 8'h00, 32'h1234_5678},
      '{1'b0, 8'h04, 32'h1234_5678},
      '{1'b1, 8'h08, 32'hFFFF_FFF6},
      '{1'b0, 8'h08, 32'h0000_0FF6},
      '{1'b0, 8'h0C, 32'h0000_0000},
      '{1'b1, 8'h10, 32'h0000_00A5},
      '{1'b0, 8'h14, 32'h0000_00A5},
      '{1'b1, 8'h04, 32'h0000_0055},
      '{1'b0, 8'h04, 32'h1234_5678},
      '{1'b1, 8'h44, 32'h0000_DEAD},
      '{1'b0, 8'h44, 32'h0000_0000},
      '{1'b0, 8'hF0, 32'h0000_0000},
      '{1'b1, 8'h38, 32'h0000_0006},
      '{1'b0, 8'h38, 32'h0000_0006},
      '{1'b0, 8'h3C, 32'h0000_0000}
    };

    // Power-on reset state
    repeat (3) step();
    RESET = 1'b0;
    check("rst hrdata", HRDATA, 32'h0);
    check("rst irq", {28'b0, IRQ}, 32'h0);
    check("rst timer_irq", {31'b0, TIMER_IRQ}, 32'h0);
    check("rst hreadyout", {31'b0, HREADYOUT}, 32'h1);

    // Register table, all channels disabled
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr)
        bus_write(tbl[i].addr, tbl[i].data);
      else
        bus_read(tbl[i].addr, tbl[i].data, $sformatf("tbl%0d@%02h", i, tbl[i].addr));
    end
    do_reset(2);

    // Periodic ch0: LOAD=4, prescale 0 -> PEND every 5 cycles
    bus_write(8'h00, 32'd4);
    bus_write(8'h08, 32'h5);
    c0 = cyc;
    for (int n = 1; n <= 5; n++) begin
      step();
      check($sformatf("per irq0 n=%0d", n), {31'b0, IRQ[0]}, {31'b0, n == 5});
    end
    bus_write(8'h0C, 32'h1);
    check("per clr irq0", {31'b0, IRQ[0]}, 32'h0);
    while (cyc - c0 < 10) begin
      step();
      d = cyc - c0;
      check($sformatf("per re irq0 d=%0d", d), {31'b0, IRQ[0]}, {31'b0, d == 10});
    end
    check("per timer_irq", {31'b0, TIMER_IRQ}, 32'h1);

    // Reset mid-count with IRQ pending
    step();
    RESET = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      check("midrst timer_irq", {31'b0, TIMER_IRQ}, 32'h0);
      check("midrst hreadyout", {31'b0, HREADYOUT}, 32'h1);
      check("midrst hrdata", HRDATA, 32'h0);
    end
    RESET = 1'b0;
    bus_read(8'h00, 32'h0, "midrst load0");
    bus_read(8'h04, 32'h0, "midrst value0");
    bus_read(8'h08, 32'h0, "midrst ctrl0");
    bus_read(8'h0C, 32'h0, "midrst status0");
    check("midrst irq after", {28'b0, IRQ}, 32'h0);

    // One-shot ch1: LOAD=2, PRESCALE=3 -> PEND after 12 cycles, EN clears
    bus_write(8'h10, 32'd2);
    bus_write(8'h18, 32'h37);
    for (int n = 1; n <= 12; n++) begin
      step();
      check($sformatf("oneshot irq1 n=%0d", n), {31'b0, IRQ[1]}, {31'b0, n == 12});
    end
    bus_read(8'h18, 32'h36, "oneshot ctrl1");
    bus_read(8'h14, 32'h0, "oneshot value1");
    bus_write(8'h1C, 32'h1);
    for (int n = 0; n < 20; n++) begin
      step();
      check("oneshot no refire", {31'b0, IRQ[1]}, 32'h0);
    end
    bus_read(8'h14, 32'h0, "oneshot value1 hold");

    // Collision ch2: clear lands on the expiry edge -> PEND stays set
    bus_write(8'h20, 32'd3);
    bus_write(8'h28, 32'h5);
    c0 = cyc;
    repeat (6) step();
    bus_write(8'h2C, 32'h1);
    check("collide at edge", cyc - c0, 32'd8);
    check("collide irq2", {31'b0, IRQ[2]}, 32'h1);
    step();
    check("collide irq2 hold", {31'b0, IRQ[2]}, 32'h1);
    bus_write(8'h2C, 32'h1);
    check("plain clr irq2", {31'b0, IRQ[2]}, 32'h0);
    do_reset(2);

    // Multi-channel: ch0 period 4, ch3 period 8, then mask ch0
    bus_write(8'h00, 32'd3);
    bus_write(8'h30, 32'd7);
    bus_write(8'h08, 32'h5);
    c0 = cyc;
    bus_write(8'h38, 32'h5);
    while (cyc - c0 < 12) begin
      step();
      d = cyc - c0;
      check($sformatf("multi irq d=%0d", d), {28'b0, IRQ}, {28'b0, d >= 10, 1'b0, 1'b0, d >= 4});
      check($sformatf("multi tirq d=%0d", d), {31'b0, TIMER_IRQ}, {31'b0, d >= 4});
    end
    bus_write(8'h08, 32'h1);
    check("mask irq0", {31'b0, IRQ[0]}, 32'h0);
    check("mask tirq", {31'b0, TIMER_IRQ}, 32'h1);
    bus_read(8'h0C, 32'h1, "mask status0");
    step();
    bus_write(8'h3C, 32'h1);
    check("mask clr3 at", cyc - c0, 32'd19);
    while (cyc - c0 < 26) begin
      step();
      d = cyc - c0;
      check($sformatf("mask tirq d=%0d", d), {31'b0, TIMER_IRQ}, {31'b0, d >= 26});
      check($sformatf("mask irq0 d=%0d", d), {31'b0, IRQ[0]}, 32'h0);
    end
    do_reset(2);

    // Back-to-back: write LOAD ch2 then read VALUE ch2 in the next address phase
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = 32'h20;
    step();
    HWDATA = 32'h0000_CAFE;
    HADDR  = 32'h24;
    HWRITE = 1'b0;
    begin
      sb_t e;
      e.name = "b2b value2";
      e.exp  = 32'h0000_CAFE;
      sb_q.push_back(e);
    end
    $display("wr [0x20] <= 0x0000cafe (pipelined)");
    step();
    idle_bus();
    sample_read();
    step();
    bus_read(8'h40, 32'h0, "unmapped 0x40");
    check("sb drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
